// File: rtl/afe_ro_buffer_if.sv
// Readout handshake between the AFE sample buffer and the uDMA write side.
// The buffer is the responder (slave); the uDMA side is the master.
interface afe_ro_buffer_if #(
  parameter int DW = 32,
  parameter int AW = 12
);
  logic          ro_valid;
  logic          ro_buf_ce;
  logic          ro_vtransfer;
  logic [DW-1:0] ro_rdata;
  logic [AW-1:0] ro_raddr;

  modport slave (
    output ro_valid,
    output ro_rdata,
    output ro_raddr,
    input  ro_buf_ce,
    input  ro_vtransfer
  );

  modport master (
    input  ro_valid,
    input  ro_rdata,
    input  ro_raddr,
    output ro_buf_ce,
    output ro_vtransfer
  );
endinterface

// File: rtl/afe_ro_buffer.sv
// AFE readout sample FIFO with ring-address tagging.
// Non-stalling source: a push into a full FIFO is dropped and flagged.
module afe_ro_buffer #(
  parameter int L2_DATA_WIDTH  = 32,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_en_i,
  input  logic                          cfg_clr_i,
  input  logic [L2_AWIDTH_NOAL-1:0]     cfg_base_i,
  input  logic [L2_AWIDTH_NOAL-1:0]     cfg_size_i,
  input  logic                          smp_valid_i,
  input  logic [L2_DATA_WIDTH-1:0]      smp_data_i,
  afe_ro_buffer_if.slave                ro,
  output logic                          ovf_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);
  localparam int DW    = L2_DATA_WIDTH;
  localparam int AW    = L2_AWIDTH_NOAL;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int BYTES = DW / 8;

  logic [DW-1:0] r_mem_d [FIFO_DEPTH];
  logic [AW-1:0] r_mem_a [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_fill;
  logic [AW-1:0] r_off;
  logic          r_ovf;
  logic          r_valid;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_raddr;

  logic          w_req;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_off_inc;
  logic [AW-1:0] w_off_nxt;
  logic [PW:0]   w_fill_nxt;
  logic [AW-1:0] w_tag;

  assign w_req  = smp_valid_i & cfg_en_i;
  assign w_full = (r_fill == (PW+1)'(FIFO_DEPTH));
  assign w_pop  = ro.ro_vtransfer & (r_fill != '0);
  assign w_push = w_req & (~w_full | w_pop);
  assign w_drop = w_req & w_full & ~w_pop;
  assign w_tag  = cfg_base_i + r_off;

  // One extra bit so offset+BYTES cannot wrap before the size compare
  always_comb begin
    w_off_inc = {1'b0, r_off} + (AW+1)'(BYTES);
    w_off_nxt = w_off_inc[AW-1:0];
    if (w_off_inc >= {1'b0, cfg_size_i})
      w_off_nxt = '0;
  end

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push & ~w_pop)
      w_fill_nxt = r_fill + (PW+1)'(1);
    else if (w_pop & ~w_push)
      w_fill_nxt = r_fill - (PW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_d[i] <= '0;
        r_mem_a[i] <= '0;
      end
    end else if (w_push & ~cfg_clr_i) begin
      r_mem_d[r_wptr] <= smp_data_i;
      r_mem_a[r_wptr] <= w_tag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_off   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_raddr <= '0;
    end else if (cfg_clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_fill  <= '0;
      r_off   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
        r_off  <= w_off_nxt;
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_drop)
        r_ovf <= 1'b1;
      r_fill  <= w_fill_nxt;
      r_valid <= (w_fill_nxt != '0);
      // Reload reads the pre-pop head, so ce+vtransfer re-reads it
      if (ro.ro_buf_ce) begin
        r_rdata <= r_mem_d[r_rptr];
        r_raddr <= r_mem_a[r_rptr];
      end
    end
  end

  assign ro.ro_valid = r_valid;
  assign ro.ro_rdata = r_rdata;
  assign ro.ro_raddr = r_raddr;
  assign ovf_o       = r_ovf;
  assign fill_o      = r_fill;
endmodule

// File: tb/tb_afe_ro_buffer.sv
// Directed + random bench for afe_ro_buffer.
// A queue model tracks contents, ring offset and overflow.
module tb_afe_ro_buffer;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr;
  logic [AW-1:0] base;
  logic [AW-1:0] size;
  logic          sv;
  logic [DW-1:0] sd;
  logic          ovf;
  logic [3:0]    fill;

  afe_ro_buffer_if #(.DW(DW), .AW(AW)) ro_if ();

  afe_ro_buffer #(
    .L2_DATA_WIDTH (DW),
    .L2_AWIDTH_NOAL(AW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_en_i   (en),
    .cfg_clr_i  (clr),
    .cfg_base_i (base),
    .cfg_size_i (size),
    .smp_valid_i(sv),
    .smp_data_i (sd),
    .ro         (ro_if),
    .ovf_o      (ovf),
    .fill_o     (fill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          q[$];
  int            m_off;
  bit            m_ovf;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_raddr;
  bit            m_rdk;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] o,
                     input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic model();
    bit   pop;
    bit   full;
    ent_t e;
    if (rst) begin
      q.delete();
      m_off = 0;
      m_ovf = 0;
      m_rdata = '0;
      m_raddr = '0;
      m_rdk = 1;
    end else if (clr) begin
      q.delete();
      m_off = 0;
      m_ovf = 0;
    end else begin
      pop  = ro_if.ro_vtransfer && q.size() > 0;
      full = q.size() == DEPTH;
      if (ro_if.ro_buf_ce) begin
        if (q.size() > 0) begin
          m_rdata = q[0].d;
          m_raddr = q[0].a;
          m_rdk = 1;
        end else begin
          m_rdk = 0;
        end
      end
      if (pop) void'(q.pop_front());
      if (sv && en) begin
        if (!full || pop) begin
          e.d = sd;
          e.a = AW'((int'(base) + m_off) % 4096);
          q.push_back(e);
          if (m_off + DW/8 >= int'(size)) m_off = 0;
          else m_off = m_off + DW/8;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d,
                      input bit ce, input bit vt,
                      input bit c, input bit r);
    sv = v;
    sd = d;
    ro_if.ro_buf_ce = ce;
    ro_if.ro_vtransfer = vt;
    clr = c;
    rst = r;
    @(posedge clk);
    model();
    #1;
    chk("valid", 64'(ro_if.ro_valid), 64'(q.size() != 0));
    chk("fill", 64'(fill), 64'(q.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (m_rdk) begin
      chk("rdata", 64'(ro_if.ro_rdata), 64'(m_rdata));
      chk("raddr", 64'(ro_if.ro_raddr), 64'(m_raddr));
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1, d, 0, 0, 0, 0);
  endtask

  // ce cycle, check outputs, then ce+vtransfer pops
  task automatic rd(input logic [DW-1:0] ed,
                    input logic [AW-1:0] ea);
    step(0, 0, 1, 0, 0, 0);
    chk("rd_data", 64'(ro_if.ro_rdata), 64'(ed));
    chk("rd_addr", 64'(ro_if.ro_raddr), 64'(ea));
    step(0, 0, 1, 1, 0, 0);
  endtask

  logic [AW-1:0] wrap_tags [5];

  initial begin
    wrap_tags[0] = 12'h100;
    wrap_tags[1] = 12'h104;
    wrap_tags[2] = 12'h100;
    wrap_tags[3] = 12'h104;
    wrap_tags[4] = 12'h100;
    en = 1;
    base = 12'h100;
    size = 12'h010;
    ro_if.ro_buf_ce = 0;
    ro_if.ro_vtransfer = 0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_valid", 64'(ro_if.ro_valid), 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);

    for (int i = 0; i < 3; i++) push(32'hA0 + i);
    for (int i = 0; i < 3; i++) rd(32'hA0 + i, 12'h100 + 12'(4 * i));
    chk("t1_valid_low", 64'(ro_if.ro_valid), 64'd0);

    step(0, 0, 0, 0, 1, 0);
    size = 12'h008;
    for (int i = 0; i < 5; i++) push(32'hB0 + i);
    for (int i = 0; i < 5; i++) rd(32'hB0 + i, wrap_tags[i]);

    step(0, 0, 0, 0, 1, 0);
    size = 12'h024;
    for (int i = 1; i <= 9; i++) push(i);
    chk("t3_fill", 64'(fill), 64'd8);
    chk("t3_ovf", 64'(ovf), 64'd1);
    for (int i = 1; i <= 8; i++) rd(i, 12'h100 + 12'(4 * (i - 1)));
    push(32'h55);
    rd(32'h55, 12'h120);

    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) push(32'hC0 + i);
    step(1, 32'hC8, 0, 1, 0, 0);
    chk("t4_fill", 64'(fill), 64'd8);
    chk("t4_ovf", 64'(ovf), 64'd0);

    step(0, 0, 0, 0, 1, 0);
    size = 12'h010;
    for (int i = 0; i < 4; i++) push(32'hD0 + i);
    step(0, 0, 0, 0, 1, 0);
    chk("t5_valid", 64'(ro_if.ro_valid), 64'd0);
    chk("t5_fill", 64'(fill), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    push(32'hD9);
    rd(32'hD9, 12'h100);

    push(32'hE0);
    push(32'hE1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1);
    chk("t6_rdata", 64'(ro_if.ro_rdata), 64'd0);
    chk("t6_raddr", 64'(ro_if.ro_raddr), 64'd0);
    chk("t6_fill", 64'(fill), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    chk("t6_underflow", 64'(fill), 64'd0);
    push(32'hE5);
    chk("t6_fill1", 64'(fill), 64'd1);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        base = AW'($urandom);
        case ($urandom_range(0, 4))
          0: size = 12'h000;
          1: size = 12'h002;
          2: size = 12'h008;
          3: size = 12'h014;
          default: size = 12'h020;
        endcase
      end
      if ($urandom_range(0, 29) == 0) en = ~en;
      step($urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
